// File: rtl/uart_tx_buffered_pkg.sv
// Shared constants for the buffered UART transmitter: frame geometry, baud default
// and FSM state encodings.
package uart_tx_buffered_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 434;
  localparam int unsigned DATA_BITS         = 8;
  localparam int unsigned FRAME_BITS        = 10;
  localparam int unsigned STATE_W           = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef logic [DATA_BITS-1:0] byte_t;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Debugger-side strobe interface and UART status lines of the buffered transmitter.
interface uart_tx_buffered_if;
  import uart_tx_buffered_pkg::*;

  byte_t db_data;
  logic  db_ok;
  logic  tx_serial;
  logic  tx_done;
  logic  tx_busy;
  logic  fifo_full;
  logic  overflow;

  modport master (output db_data, db_ok,
                  input  tx_serial, tx_done, tx_busy, fifo_full, overflow);
  modport slave  (input  db_data, db_ok,
                  output tx_serial, tx_done, tx_busy, fifo_full, overflow);
endinterface

// File: rtl/uart_tx_buffered_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; rdata shows the head entry so the
// consumer's register captures it on the pop edge.
module uart_tx_buffered_byte_fifo
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  byte_t wdata,
  output byte_t rdata,
  output logic  empty,
  output logic  full
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  byte_t           mem [FIFO_DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic            wr_en, rd_en;

  // A full FIFO that pops in the same cycle still accepts the write.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign rdata = mem[rd_ptr[ADDR_W-1:0]];

  always_comb begin
    wr_nxt = wr_en ? wr_ptr + PTR_ONE : wr_ptr;
    rd_nxt = rd_en ? rd_ptr + PTR_ONE : rd_ptr;
  end

  // Flags are registered from the next pointers so they always match the pointer decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[ADDR_W] != rd_nxt[ADDR_W]) &&
                (wr_nxt[ADDR_W-1:0] == rd_nxt[ADDR_W-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Debugger text-path transmitter: edge-detects db_ok, queues bytes and sends each
// as a back-to-back UART 8N1 frame, pulsing tx_done at every stop-bit end.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_buffered_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [CNT_W-1:0]   baud_cnt, baud_nxt;
  logic [2:0]         bit_idx, bit_nxt;
  byte_t              shift_reg, shift_nxt, rdata;
  logic               db_ok_d, push, pop_c, done_c, bit_end_c, empty, full;

  assign push          = bus.db_ok & ~db_ok_d;
  assign bus.fifo_full = full;

  uart_tx_buffered_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop_c),
    .wdata (bus.db_data),
    .rdata (rdata),
    .empty (empty),
    .full  (full)
  );

  // Strobe edge detect and sticky drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_ok_d      <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      db_ok_d      <= bus.db_ok;
      bus.overflow <= bus.overflow | (push & full & ~pop_c);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_idx   <= bit_nxt;
      shift_reg <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift_reg;
    pop_c     = 1'b0;
    done_c    = 1'b0;
    bit_end_c = (baud_cnt == CNT_LAST);
    if (state != ST_IDLE) baud_nxt = bit_end_c ? '0 : baud_cnt + CNT_W'(1);
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop_c     = 1'b1;
          shift_nxt = rdata;
          baud_nxt  = '0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          bit_nxt   = '0;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          shift_nxt = {1'b0, shift_reg[DATA_BITS-1:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == IDX_LAST) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit when more bytes are waiting.
        if (bit_end_c) begin
          done_c = 1'b1;
          if (!empty) begin
            pop_c     = 1'b1;
            shift_nxt = rdata;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Line is driven from the current state, so it trails the FSM by one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.tx_serial <= 1'b1;
      bus.tx_done   <= 1'b0;
      bus.tx_busy   <= 1'b0;
    end else begin
      bus.tx_serial <= (state == ST_START) ? 1'b0 :
                       (state == ST_DATA)  ? shift_reg[0] : 1'b1;
      bus.tx_done   <= done_c;
      bus.tx_busy   <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed and random strobes, a UART line decoder and a
// timing/occupancy reference model of the queue and transmitter.
module tb_uart_tx_buffered;
  import uart_tx_buffered_pkg::*;

  localparam int CPB       = 4;
  localparam int DEPTH     = 8;
  localparam int FRAME_CYC = int'(FRAME_BITS) * CPB;

  logic clk;
  logic reset;
  uart_tx_buffered_if intf();

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    frame_err = 0;
  byte_t exp_q[$];
  byte_t rx_q[$];
  int    exp_start[$];
  int    rx_start[$];
  int    done_q[$];
  int    pend_n   = 0;
  int    next_pop = 0;
  logic  exp_ovf  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Line decoder: a frame starts on the first low sample; every bit must hold for CPB samples.
  initial begin : mon
    logic [9:0] fb;
    int k, fs, bi;
    bit in_f, bad;
    in_f = 0; k = 0; fs = 0; bi = 0; bad = 0; fb = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        in_f = 0;
      end else begin
        if (!in_f && intf.tx_serial === 1'b0) begin
          in_f = 1; k = 0; fs = cyc; bad = 0; fb = '0;
        end
        if (in_f) begin
          bi = k / CPB;
          if (k % CPB == 0) fb[4'(bi)] = intf.tx_serial;
          else if (fb[4'(bi)] !== intf.tx_serial) bad = 1;
          k++;
          if (k == FRAME_CYC) begin
            in_f = 0;
            if (bad || fb[0] !== 1'b0 || fb[9] !== 1'b1) frame_err++;
            rx_q.push_back(fb[8:1]);
            rx_start.push_back(fs);
          end
        end
        if (intf.tx_done === 1'b1) done_q.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a byte pushed at edge c is accepted unless DEPTH bytes wait and no pop lands
  // at c; an idle transmitter pops at c+1, each frame then occupies FRAME_CYC edges.
  task automatic model_push(input byte_t b, input int c);
    while (pend_n > 0 && next_pop <= c) begin
      pend_n--;
      exp_start.push_back(next_pop + 1);
      next_pop += FRAME_CYC;
    end
    if (pend_n == 0 && next_pop <= c) begin
      exp_q.push_back(b);
      exp_start.push_back(c + 2);
      next_pop = c + 1 + FRAME_CYC;
    end else if (pend_n == DEPTH) begin
      exp_ovf = 1'b1;
    end else begin
      pend_n++;
      exp_q.push_back(b);
    end
  endtask

  task automatic strobe(input byte_t b, input int hold, input int gap, output int c);
    intf.db_data = b;
    intf.db_ok   = 1'b1;
    tick();
    c = cyc;
    model_push(b, c);
    chk("fifo_full", 32'(intf.fifo_full), 32'(pend_n == DEPTH));
    chk("overflow", 32'(intf.overflow), 32'(exp_ovf));
    for (int i = 1; i < hold; i++) begin
      intf.db_data = b + byte_t'(i);
      tick();
    end
    intf.db_ok = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic run_check(input string name, input bit contiguous);
    int last_done, guard, busy_gap;
    while (pend_n > 0) begin
      pend_n--;
      exp_start.push_back(next_pop + 1);
      next_pop += FRAME_CYC;
    end
    last_done = (exp_start.size() > 0) ? exp_start[$] + FRAME_CYC - 1 : cyc;
    guard = 0;
    busy_gap = 0;
    while ((cyc < last_done + 2 || intf.tx_busy !== 1'b0) && guard < 4000) begin
      if (contiguous && exp_start.size() > 0 && cyc >= exp_start[0] && cyc < last_done &&
          intf.tx_busy !== 1'b1) busy_gap++;
      tick();
      guard++;
    end
    chk({name, ":timeout"}, 32'(guard < 4000), 32'd1);
    chk({name, ":rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk({name, ":rx_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
      chk({name, ":frame_start"}, 32'(rx_start[i]), 32'(exp_start[i]));
    end
    chk({name, ":done_count"}, 32'(done_q.size()), 32'(exp_start.size()));
    for (int i = 0; i < exp_start.size() && i < done_q.size(); i++)
      chk({name, ":done_cycle"}, 32'(done_q[i]), 32'(exp_start[i] + FRAME_CYC - 1));
    if (contiguous) chk({name, ":busy_gap"}, 32'(busy_gap), 32'd0);
    chk({name, ":frame_err"}, 32'(frame_err), 32'd0);
    chk({name, ":idle_busy"}, 32'(intf.tx_busy), 32'd0);
    chk({name, ":idle_line"}, 32'(intf.tx_serial), 32'd1);
    chk({name, ":overflow"}, 32'(intf.overflow), 32'(exp_ovf));
    exp_q.delete(); rx_q.delete(); exp_start.delete(); rx_start.delete(); done_q.delete();
  endtask

  initial begin : stim
    int c, c0;
    byte_t burst[6];
    burst = '{8'h73, 8'h61, 8'h62, 8'h72, 8'h6F, 8'h58};
    reset = 1'b0;
    intf.db_ok = 1'b0;
    intf.db_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", 32'(intf.tx_serial), 32'd1);
    chk("rst_done", 32'(intf.tx_done), 32'd0);
    chk("rst_busy", 32'(intf.tx_busy), 32'd0);
    chk("rst_full", 32'(intf.fifo_full), 32'd0);
    chk("rst_ovf", 32'(intf.overflow), 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // 1: single byte with explicit latency checks
    strobe(8'h73, 1, 0, c);
    chk("t1:line_at_k", 32'(intf.tx_serial), 32'd1);
    tick();
    chk("t1:line_at_k1", 32'(intf.tx_serial), 32'd1);
    chk("t1:busy_at_k1", 32'(intf.tx_busy), 32'd1);
    tick();
    chk("t1:line_at_k2", 32'(intf.tx_serial), 32'd0);
    run_check("t1", 1'b1);

    // 2: burst, one strobe per two cycles
    foreach (burst[i]) strobe(burst[i], 1, 1, c);
    run_check("t2", 1'b1);

    // 3: level held 8 cycles with changing data
    strobe(8'hA0, 8, 1, c);
    run_check("t3", 1'b1);

    // 6: all-zero then all-one byte
    strobe(8'h00, 1, 1, c);
    strobe(8'hFF, 1, 1, c);
    run_check("t6", 1'b1);

    // 4: overflow
    for (int i = 0; i < 10; i++) strobe(byte_t'(i), 1, 1, c);
    chk("t4:ovf_flag_model", 32'(exp_ovf), 32'(intf.overflow));
    run_check("t4", 1'b1);

    // 5: reset during DATA bit 3 of 0x55 with two bytes queued
    strobe(8'h55, 1, 1, c0);
    strobe(8'hAA, 1, 1, c);
    strobe(8'hBB, 1, 1, c);
    while (cyc < c0 + 18) tick();
    chk("t5:pre_reset_line", 32'(intf.tx_serial), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("t5:rst_line", 32'(intf.tx_serial), 32'd1);
    chk("t5:rst_busy", 32'(intf.tx_busy), 32'd0);
    chk("t5:rst_ovf", 32'(intf.overflow), 32'd0);
    chk("t5:rst_done_seen", 32'(done_q.size()), 32'd0);
    chk("t5:rst_rx_seen", 32'(rx_q.size()), 32'd0);
    repeat (2) tick();
    chk("t5:rst_held_done", 32'(intf.tx_done), 32'd0);
    reset = 1'b1;
    exp_q.delete(); exp_start.delete(); rx_q.delete(); rx_start.delete(); done_q.delete();
    pend_n = 0;
    next_pop = 0;
    exp_ovf = 1'b0;
    tick();
    strobe(8'h3C, 1, 1, c);
    run_check("t5", 1'b1);

    // 7: random bytes, hold lengths and gaps
    for (int i = 0; i < 24; i++)
      strobe(byte_t'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 14)), c);
    run_check("t7", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
